polyphase_interp_fir: RTL and testbench

- Parametrised polyphase interpolation FIR for the Tx interpolation chain.
- Replaces the fixed single-branch comb stage with one block that covers every branch: PHASES branches of NTAPS taps each.
- Coefficients are set by a packed parameter; output widths use round-and-saturate.
- One input sample produces PHASES output samples, time-multiplexed on a valid/ready stream with backpressure.

---
 rtl/polyphase_interp_fir.sv | 134 +++++++++++++
 tb/tb_polyphase_interp_fir.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_interp_fir.sv
// Polyphase interpolation FIR. Each accepted sample produces PHASES outputs, one per cycle,
// on a valid/ready stream. Outputs are rounded half-up, shifted, then saturated.
module polyphase_interp_fir #(
    parameter int unsigned IN_W   = 11,
    parameter int unsigned COEF_W = 10,
    parameter int unsigned OUT_W  = 20,
    parameter int unsigned NTAPS  = 4,
    parameter int unsigned PHASES = 2,
    parameter int unsigned SHIFT  = 0,
    parameter logic [PHASES*NTAPS*COEF_W-1:0] COEFS = {
        10'd1, 10'd161, 10'd315, 10'd35,   // phase1: k3..k0
        10'd35, 10'd315, 10'd161, 10'd1    // phase0: k3..k0
    }
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          clr_i,
    input  logic signed [IN_W-1:0]                        in_data_i,
    input  logic                                          in_valid_i,
    output logic                                          in_ready_o,
    output logic signed [OUT_W-1:0]                       out_data_o,
    output logic                                          out_valid_o,
    input  logic                                          out_ready_i,
    output logic [((PHASES > 1) ? $clog2(PHASES) : 1)-1:0] out_phase_o,
    output logic                                          out_sat_o
);

    localparam int unsigned ACC_W = IN_W + COEF_W + $clog2(NTAPS);
    localparam int unsigned PH_W  = (PHASES > 1) ? $clog2(PHASES) : 1;

    localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(((64'd1) << SHIFT) >> 1);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W:0] MINV = ~MAXV;

    logic [NTAPS-1:0][IN_W-1:0] x_q, x_d;
    logic                       busy_q, busy_d;
    logic [PH_W-1:0]            ph_q, ph_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]    out_data_q, out_data_d;
    logic [PH_W-1:0]            out_phase_q, out_phase_d;
    logic                       out_sat_q, out_sat_d;

    logic                       issue, last, accept;
    logic [COEF_W-1:0]          coef;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W:0]      rnd;
    logic signed [OUT_W-1:0]    res;
    logic                       sat;

    // Dot product of the registered delay line with the current phase's coefficient row.
    always_comb begin
        coef = '0;
        acc  = '0;
        for (int k = 0; k < NTAPS; k++) begin
            coef = COEFS[(int'(ph_q) * NTAPS + k) * COEF_W +: COEF_W];
            acc  = acc + ACC_W'($signed(coef)) * ACC_W'($signed(x_q[k]));
        end
        rnd = ($signed({acc[ACC_W-1], acc}) + RND) >>> SHIFT;
        res = rnd[OUT_W-1:0];
        sat = 1'b0;
        if (rnd > MAXV) begin
            res = MAXV[OUT_W-1:0];
            sat = 1'b1;
        end else if (rnd < MINV) begin
            res = MINV[OUT_W-1:0];
            sat = 1'b1;
        end
    end

    always_comb begin
        issue      = busy_q && (!out_valid_q || out_ready_i);
        last       = (ph_q == PH_W'(PHASES - 1));
        in_ready_o = !busy_q || (issue && last);
        accept     = in_valid_i && in_ready_o;

        x_d         = x_q;
        busy_d      = busy_q;
        ph_d        = ph_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_phase_d = out_phase_q;
        out_sat_d   = out_sat_q;

        if (issue) begin
            out_data_d  = res;
            out_sat_d   = sat;
            out_phase_d = ph_q;
            out_valid_d = 1'b1;
            if (!last) begin
                ph_d = ph_q + PH_W'(1);
            end else begin
                busy_d = 1'b0;
            end
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        // Accept overrides the end-of-burst clear; issue above already used the old line.
        if (accept) begin
            for (int k = NTAPS - 1; k > 0; k--) begin
                x_d[k] = x_q[k-1];
            end
            x_d[0] = in_data_i;
            busy_d = 1'b1;
            ph_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            x_q         <= '0;
            busy_q      <= 1'b0;
            ph_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_phase_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            x_q         <= x_d;
            busy_q      <= busy_d;
            ph_q        <= ph_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_phase_q <= out_phase_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_phase_o = out_phase_q;
    assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_polyphase_interp_fir.sv
// Directed bench: impulse, DC, backpressure, saturation, rounding and mid-burst reset/clr,
// using three instances (default, OUT_W=18, SHIFT=2) driven by one shared stimulus.
module tb_polyphase_interp_fir;

    logic              clk = 1'b0;
    logic              rst_n, clr, in_valid, out_ready;
    logic signed [10:0] in_data;

    logic               in_ready, out_valid, out_sat, out_phase;
    logic signed [19:0] out_data;
    logic               s_in_ready, s_out_valid, s_out_sat, s_out_phase;
    logic signed [17:0] s_out_data;
    logic               r_in_ready, r_out_valid, r_out_sat, r_out_phase;
    logic signed [19:0] r_out_data;

    int n_checks = 0;
    int n_fail   = 0;
    int q_data[$], q_phase[$], q18_data[$], q18_sat[$], qr_data[$];

    int IMP[8] = '{1, 35, 161, 315, 315, 161, 35, 1};
    int RND[8] = '{0, 9, 40, 79, 79, 40, 9, 0};
    int DC[12] = '{1, 35, 162, 350, 477, 511, 512, 512, 512, 512, 512, 512};

    always #5 clk = ~clk;

    polyphase_interp_fir dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .out_data_o(out_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_phase_o(out_phase), .out_sat_o(out_sat)
    );

    polyphase_interp_fir #(.OUT_W(18)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(s_in_ready), .out_data_o(s_out_data), .out_valid_o(s_out_valid),
        .out_ready_i(out_ready), .out_phase_o(s_out_phase), .out_sat_o(s_out_sat)
    );

    polyphase_interp_fir #(.SHIFT(2)) dut_rnd (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(r_in_ready), .out_data_o(r_out_data), .out_valid_o(r_out_valid),
        .out_ready_i(out_ready), .out_phase_o(r_out_phase), .out_sat_o(r_out_sat)
    );

    // A transfer happens at the next rising edge when valid and ready are both high here.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_data.push_back(int'(out_data));
            q_phase.push_back(int'(out_phase));
            q18_data.push_back(int'(s_out_data));
            q18_sat.push_back(int'(s_out_sat));
            qr_data.push_back(int'(r_out_data));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_queues();
        q_data.delete(); q_phase.delete(); q18_data.delete(); q18_sat.delete(); qr_data.delete();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_queues();
    endtask

    task automatic push(input int d, output int waits);
        int n = 0;
        in_data  = 11'(d);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        waits = n;
        check("push_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        int c = 0;
        while (q_data.size() < n && c < 100) begin
            @(posedge clk);
            c++;
        end
        #1 check("drain_count", q_data.size(), n);
    endtask

    task automatic run_impulse(input string tag);
        int w;
        clear_queues();
        push(1, w);
        check({tag, "_lat_e0_valid"}, int'(out_valid), 0);
        @(posedge clk);
        #1 check({tag, "_lat_e1_valid"}, int'(out_valid), 1);
        for (int i = 0; i < 3; i++) push(0, w);
        drain(8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_data%0d", tag, i), q_data[i], IMP[i]);
            check($sformatf("%s_phase%0d", tag, i), q_phase[i], i % 2);
            check($sformatf("%s_rnd%0d", tag, i), qr_data[i], RND[i]);
            check($sformatf("%s_w18_%0d", tag, i), q18_data[i], IMP[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_phase", int'(out_phase), 0);
        check("rst_sat", int'(out_sat), 0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", int'(in_ready), 1);

        // Impulse, also exercises rounding (SHIFT=2) and the 18-bit instance unsaturated.
        run_impulse("imp");

        // DC step: after filling, every output is the coefficient row sum; one accept per 2 cycles.
        reset_dut();
        push(1, w);
        for (int i = 1; i < 6; i++) begin
            push(1, w);
            check($sformatf("dc_waits%0d", i), w, 1);
        end
        drain(12);
        for (int i = 0; i < 12; i++) check($sformatf("dc_data%0d", i), q_data[i], DC[i]);

        // Saturation: full-scale negative input hits -2^19 exactly.
        reset_dut();
        for (int i = 0; i < 4; i++) push(-1024, w);
        drain(8);
        check("sat20_d6", q_data[6], -524288);
        check("sat20_d7", q_data[7], -524288);
        check("sat18_d1", q18_data[1], -35840);
        check("sat18_s1", q18_sat[1], 0);
        check("sat18_d6", q18_data[6], -131072);
        check("sat18_s6", q18_sat[6], 1);
        check("sat18_d7", q18_data[7], -131072);
        check("sat18_s7", q18_sat[7], 1);

        // Backpressure while phase1 of the first sample is presented.
        reset_dut();
        fork
            begin
                push(1, w);
                for (int i = 0; i < 3; i++) push(0, w);
            end
            begin
                int n = 0;
                int found = 0;
                while (found == 0 && n < 30) begin
                    @(posedge clk);
                    #2;
                    if (out_valid && out_phase == 1'b1) found = 1;
                    n++;
                end
                check("bp_found", found, 1);
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk);
                    #2;
                    check($sformatf("bp_valid%0d", i), int'(out_valid), 1);
                    check($sformatf("bp_data%0d", i), int'(out_data), 35);
                    check($sformatf("bp_phase%0d", i), int'(out_phase), 1);
                    check($sformatf("bp_in_ready%0d", i), int'(in_ready), 0);
                end
                out_ready = 1'b1;
            end
        join
        drain(8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bp_seq%0d", i), q_data[i], IMP[i]);
            check($sformatf("bp_seqph%0d", i), q_phase[i], i % 2);
        end

        // Reset between phase0 and phase1, then clr the same way.
        for (int mode = 0; mode < 2; mode++) begin
            string tag;
            tag = (mode == 0) ? "mid_rst" : "mid_clr";
            reset_dut();
            push(1, w);
            @(posedge clk);
            #1;
            check({tag, "_ph0_valid"}, int'(out_valid), 1);
            check({tag, "_ph0_data"}, int'(out_data), 1);
            if (mode == 0) rst_n = 1'b0;
            else clr = 1'b1;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            clr = 1'b0;
            check({tag, "_valid"}, int'(out_valid), 0);
            check({tag, "_data"}, int'(out_data), 0);
            check({tag, "_in_ready"}, int'(in_ready), 1);
            @(posedge clk);
            #1 check({tag, "_no_ph1"}, int'(out_valid), 0);
            run_impulse({tag, "_imp"});
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
